stopwatch_display: RTL and testbench

//  Downstream of the stopwatch time counter: converts binary hours/minutes/seconds/centiseconds to BCD
//  and drives the 8-digit multiplexed seven-segment display (SEG/DP/AN, all active-low).

---
 rtl/stopwatch_display.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// Eight-digit multiplexed seven-segment driver for the stopwatch: snapshots the time once per
// scan frame, converts each field to BCD with a sequential double-dabble engine and scans digits.
module stopwatch_display #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 8000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] centiseconds,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [7:0] AN
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [6:0] DASH = 7'b0111111;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_t;

    logic [CNT_W-1:0] refresh_cnt;
    logic             tick;
    logic             frame_wrap;
    logic [2:0]       idx;
    logic [3:0]       digit;
    logic [6:0]       digit_seg;
    logic             separator;

    state_t           state;
    logic [1:0]       fld;
    logic [2:0]       shift_cnt;

    // Field order everywhere: 0 = centiseconds, 1 = seconds, 2 = minutes, 3 = hours
    logic [3:0][6:0]  snap;
    logic [6:0]       bin;
    logic [7:0]       bcd;
    logic             ovf;
    logic [3:0][7:0]  pend_bcd;
    logic [3:0]       pend_dash;
    logic [3:0][7:0]  disp_bcd;
    logic [3:0]       disp_dash;

    function automatic logic [6:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    seg_font = 7'b1000000;
            4'd1:    seg_font = 7'b1111001;
            4'd2:    seg_font = 7'b0100100;
            4'd3:    seg_font = 7'b0110000;
            4'd4:    seg_font = 7'b0011001;
            4'd5:    seg_font = 7'b0010010;
            4'd6:    seg_font = 7'b0000010;
            4'd7:    seg_font = 7'b1111000;
            4'd8:    seg_font = 7'b0000000;
            4'd9:    seg_font = 7'b0010000;
            default: seg_font = DASH;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [14:0] dd_step(input logic [7:0] b, input logic [6:0] v);
        logic [7:0] a;
        a = b;
        if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
        if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
        return {a[6:0], v, 1'b0};
    endfunction

    assign tick       = (refresh_cnt == CNT_W'(DIV - 1));
    assign frame_wrap = tick && (idx == 3'd7);

    always_comb begin
        digit     = idx[0] ? disp_bcd[idx[2:1]][7:4] : disp_bcd[idx[2:1]][3:0];
        digit_seg = disp_dash[idx[2:1]] ? DASH : seg_font(digit);
        separator = (idx == 3'd6) || (idx == 3'd4) || (idx == 3'd2);
    end

    // Refresh divider and scan: outputs latch the digit at idx on the tick, then idx advances
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            refresh_cnt <= '0;
            idx         <= 3'd0;
            AN          <= 8'hFF;
            SEG         <= 7'h7F;
            DP          <= 1'b1;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
                AN  <= ~(8'd1 << idx);
                SEG <= digit_seg;
                DP  <= ~separator;
            end
        end
    end

    // Conversion sequencer; display registers update atomically in DONE
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= S_IDLE;
            fld       <= 2'd0;
            shift_cnt <= 3'd0;
            disp_bcd  <= '0;
            disp_dash <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    fld <= 2'd0;
                    if (frame_wrap) state <= S_LOAD;
                end
                S_LOAD: begin
                    shift_cnt <= 3'd0;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd6) state <= S_STORE;
                end
                S_STORE: begin
                    if (fld == 2'd3) begin
                        state <= S_DONE;
                    end else begin
                        fld   <= fld + 2'd1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    disp_bcd  <= pend_bcd;
                    disp_dash <= pend_dash;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Conversion datapath
    always_ff @(posedge CLK100MHZ) begin
        if (state == S_IDLE && frame_wrap) begin
            snap[0] <= centiseconds;
            snap[1] <= {1'b0, seconds};
            snap[2] <= {1'b0, minutes};
            snap[3] <= {2'b00, hours};
        end
        case (state)
            S_LOAD: begin
                bin <= snap[fld];
                bcd <= 8'd0;
                ovf <= (snap[fld] > 7'd99);
            end
            S_SHIFT: {bcd, bin} <= dd_step(bcd, bin);
            S_STORE: begin
                pend_bcd[fld]  <= bcd;
                pend_dash[fld] <= ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized bench for stopwatch_display against a frame-level reference model of the display.
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] centiseconds;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;

    always #5 clk = ~clk;

    stopwatch_display #(
        .CLK_HZ    (100_000_000),
        .REFRESH_HZ(1_562_500)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .centiseconds(centiseconds),
        .SEG         (seg),
        .DP          (dp),
        .AN          (an)
    );

    localparam int DIV = 64;

    logic [6:0] font_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int errors = 0;
    int checks = 0;

    // Reference: values currently on the display per field (0=cs,1=s,2=m,3=h)
    int         shown [4];
    int         edges;
    int         tick_num;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) shown[i] = 0;
        edges    = 0;
        tick_num = 0;
        exp_an   = 8'hFF;
        exp_seg  = 7'h7F;
        exp_dp   = 1'b1;
    endtask

    task automatic model_tick();
        int k;
        int v;
        k = tick_num % 8;
        v = shown[k / 2];
        exp_an = ~(8'd1 << k);
        if (v > 99) exp_seg = 7'b0111111;
        else        exp_seg = font_tbl[(k % 2 == 1) ? (v / 10) : (v % 10)];
        exp_dp = !(k == 2 || k == 4 || k == 6);
        if (k == 7) begin
            shown[0] = centiseconds;
            shown[1] = seconds;
            shown[2] = minutes;
            shown[3] = hours;
        end
        tick_num++;
    endtask

    task automatic check_outputs();
        check("AN",  16'(an),  16'(exp_an));
        check("SEG", 16'(seg), 16'(exp_seg));
        check("DP",  16'(dp),  16'(exp_dp));
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            edges++;
            if (edges % DIV == 0) model_tick();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic randomize_inputs();
        hours        = 5'($urandom_range(0, 31));
        minutes      = 6'($urandom_range(0, 63));
        seconds      = 6'($urandom_range(0, 63));
        centiseconds = 7'($urandom_range(0, 127));
    endtask

    initial begin
        bit found;
        rst_n        = 1'b0;
        hours        = 5'd12;
        minutes      = 6'd34;
        seconds      = 6'd56;
        centiseconds = 7'd78;
        model_reset();
        run(5);
        rst_n = 1'b1;

        // Fixed time: first frame shows zeros, then 12:34:56.78
        run(DIV * 8 * 2 + 20);

        // Change seconds mid-frame; only takes effect after the next wrap
        seconds = 6'd57;
        run(DIV * 8 * 2);

        // Out-of-range centiseconds shows dashes
        hours = 5'd0; minutes = 6'd0; seconds = 6'd0; centiseconds = 7'd100;
        run(DIV * 8 * 2);

        // Reset between edges while the converter is shifting
        randomize_inputs();
        found = 1'b0;
        for (int i = 0; i < DIV * 8 * 2 && !found; i++) begin
            step();
            if (tick_num > 0 && tick_num % 8 == 0 && edges % DIV == 5) found = 1'b1;
        end
        check("midshift_wait", 16'(found), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        run(3);
        rst_n = 1'b1;
        run(DIV * 8 * 2 + 10);

        // Random fields changing at random moments
        for (int i = 0; i < DIV * 8 * 10; i++) begin
            step();
            if ($urandom_range(0, 49) == 0) randomize_inputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
